// File: rtl/div_16bit_seq.sv
// rtl/div_16bit_seq.sv - sequential radix-2 restoring divider, one quotient bit per clock
// Optional signed mode is enabled by defining DIV_SIGNED_EN (adds the signed_op input).
module div_16bit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic            dbz_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
`ifdef DIV_SIGNED_EN
  logic            neg_quo_q;
  logic            neg_rem_q;
`endif

  logic [WIDTH-1:0] dvnd_mag_d;
  logic [WIDTH-1:0] dvsr_mag_d;
  logic             neg_quo_d;
  logic             neg_rem_d;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // Operand magnitudes and result signs as seen on the accepting edge
  always_comb begin
    dvnd_mag_d = dividend;
    dvsr_mag_d = divisor;
    neg_quo_d  = 1'b0;
    neg_rem_d  = 1'b0;
`ifdef DIV_SIGNED_EN
    if (signed_op) begin
      if (dividend[WIDTH-1]) dvnd_mag_d = -dividend;
      if (divisor[WIDTH-1])  dvsr_mag_d = -divisor;
      neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_d = dividend[WIDTH-1];
    end
`endif
  end

  // One restoring step: shift {R,Q} left, trial-subtract, keep or restore
  always_comb begin
    shifted_d = {rem_q, quo_q[WIDTH-1]};
    diff_d    = shifted_d - {1'b0, dvsr_q};
    if (!diff_d[WIDTH]) begin
      rem_d = diff_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered handshake outputs and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              // Divide by zero skips the iterations entirely
              state_q     <= DONE;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              ready_q     <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q   <= CALC;
              count_q   <= '0;
              rem_q     <= '0;
              quo_q     <= dvnd_mag_d;
              dvsr_q    <= dvsr_mag_d;
              dbz_q     <= 1'b0;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
`ifdef DIV_SIGNED_EN
              neg_quo_q <= neg_quo_d;
              neg_rem_q <= neg_rem_d;
`endif
            end
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            // Results become visible only on the edge that enters DONE
            state_q <= DONE;
`ifdef DIV_SIGNED_EN
            quotient_q  <= neg_quo_q ? -quo_d : quo_d;
            remainder_q <= neg_rem_q ? -rem_d : rem_d;
`else
            quotient_q  <= quo_d;
            remainder_q <= rem_d;
`endif
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

`ifndef DIV_SIGNED_EN
  // Sign helpers only matter in signed builds
  logic unused_sign;
  assign unused_sign = neg_quo_d ^ neg_rem_d;
`endif

endmodule

// File: tb/tb_div_16bit_seq.sv
// tb/tb_div_16bit_seq.sv - self-checking bench for div_16bit_seq
module tb_div_16bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  div_16bit_seq #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef DIV_SIGNED_EN
    .signed_op(signed_op),
`endif
    .dividend(dividend),
    .divisor(divisor),
    .ready(ready),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division following the result rules
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sg,
                       output logic [15:0] q, output logic [15:0] r, output logic z);
    int sa, sb;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; z = 1'b1;
    end else if (sg) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      q = 16'(sa / sb); r = 16'(sa % sb); z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  // Issue one operation and capture latency, busy cycles, results and the following done
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sg,
                       output int lat, output int bcnt, output logic [15:0] q,
                       output logic [15:0] r, output logic z, output logic d2);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; signed_op = sg;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom); signed_op = 1'($urandom);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    q = quotient; r = remainder; z = div_by_zero;
    @(posedge clk); #1;
    d2 = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 16'h1234; divisor = 16'h0056; signed_op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (quotient !== 16'h0) begin bad++; $display("FAIL reset_quotient got=%h want=0000", quotient); end
    total++; if (remainder !== 16'h0) begin bad++; $display("FAIL reset_remainder got=%h want=0000", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bcnt; logic [15:0] q, r; logic z, d2;
    do_op(16'd1000, 16'd7, 1'b0, lat, bcnt, q, r, z, d2);
    total++; if (lat != 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", lat); end
    total++; if (bcnt != 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=16", bcnt); end
    total++; if (q !== 16'd142) begin bad++; $display("FAIL basic_quotient got=%0d want=142", q); end
    total++; if (r !== 16'd6) begin bad++; $display("FAIL basic_remainder got=%0d want=6", r); end
    total++; if (z !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b want=0", z); end
    total++; if (d2 !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", d2); end
  endtask

  task automatic test_edges();
    logic [15:0] ta[3] = '{16'd65535, 16'd12, 16'd0};
    logic [15:0] tb[3] = '{16'd1, 16'd13, 16'd5};
    logic [15:0] tq[3] = '{16'hFFFF, 16'd0, 16'd0};
    logic [15:0] tr[3] = '{16'd0, 16'd12, 16'd0};
    int lat, bcnt; logic [15:0] q, r, eq, er, a, b; logic z, d2, ez;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], 1'b0, lat, bcnt, q, r, z, d2);
      total++; if (q !== tq[i] || r !== tr[i] || lat != 16)
        begin bad++; $display("FAIL edge_%0d got=%h/%h lat=%0d want=%h/%h lat=16", i, q, r, lat, tq[i], tr[i]); end
    end
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'd0;
        1: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      model(a, b, 1'b0, eq, er, ez);
      do_op(a, b, 1'b0, lat, bcnt, q, r, z, d2);
      total++; if (q !== eq || r !== er || z !== ez || lat != ((b == 0) ? 0 : 16))
        begin bad++; $display("FAIL rand_%0d %h/%h got=%h r%h z%b lat=%0d want=%h r%h z%b", i, a, b, q, r, z, lat, eq, er, ez); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt; logic [15:0] q, r; logic z, d2;
    do_op(16'd5, 16'd0, 1'b0, lat, bcnt, q, r, z, d2);
    total++; if (lat != 0) begin bad++; $display("FAIL dbz_latency got=%0d want=0", lat); end
    total++; if (q !== 16'hFFFF || r !== 16'd5 || z !== 1'b1)
      begin bad++; $display("FAIL dbz_result got=%h r%h z%b want=ffff r0005 z1", q, r, z); end
    total++; if (d2 !== 1'b0) begin bad++; $display("FAIL dbz_done_width got=%b want=0", d2); end
    do_op(16'd10, 16'd3, 1'b0, lat, bcnt, q, r, z, d2);
    total++; if (q !== 16'd3 || r !== 16'd1 || z !== 1'b0)
      begin bad++; $display("FAIL after_dbz got=%0d r%0d z%b want=3 r1 z0", q, r, z); end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 16'd1234; divisor = 16'd56; signed_op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      start = (lat == 3 || lat == 8);
      if (start) begin dividend = 16'd999; divisor = 16'd2; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++; if (lat != 16) begin bad++; $display("FAIL ignore_latency got=%0d want=16", lat); end
    total++; if (quotient !== 16'd22 || remainder !== 16'd2)
      begin bad++; $display("FAIL ignore_result got=%0d r%0d want=22 r2", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 16'd500; divisor = 16'd3; signed_op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (quotient !== 16'd166 || remainder !== 16'd2 || lat != 16)
      begin bad++; $display("FAIL b2b_first got=%0d r%0d lat=%0d want=166 r2 lat=16", quotient, remainder, lat); end
    start = 1'b1; dividend = 16'd777; divisor = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0)
      begin bad++; $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done); end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (quotient !== 16'd77 || remainder !== 16'd7 || lat != 16)
      begin bad++; $display("FAIL b2b_second got=%0d r%0d lat=%0d want=77 r7 lat=16", quotient, remainder, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, pulses; logic [15:0] q, r; logic z, d2;
    @(negedge clk);
    start = 1'b1; dividend = 16'd40000; divisor = 16'd3; signed_op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 7) begin @(posedge clk); #1; lat++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL midrst_ctrl got rdy=%b busy=%b done=%b want 1/0/0", ready, busy, done); end
    total++; if (quotient !== 16'd0 || remainder !== 16'd0)
      begin bad++; $display("FAIL midrst_result got=%h r%h want=0000 r0000", quotient, remainder); end
    pulses = 0;
    repeat (20) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", pulses); end
    do_op(16'd100, 16'd9, 1'b0, lat, bcnt, q, r, z, d2);
    total++; if (q !== 16'd11 || r !== 16'd1 || z !== 1'b0)
      begin bad++; $display("FAIL midrst_after got=%0d r%0d want=11 r1", q, r); end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [15:0] ta[4] = '{16'hFF9C, 16'd100, 16'h8000, 16'hFFF9};
    logic [15:0] tb[4] = '{16'd7, 16'hFFF9, 16'hFFFF, 16'd0};
    logic [15:0] tq[4] = '{16'hFFF2, 16'hFFF2, 16'h8000, 16'hFFFF};
    logic [15:0] tr[4] = '{16'hFFFE, 16'd2, 16'd0, 16'hFFF9};
    int lat, bcnt; logic [15:0] q, r, eq, er, a, b; logic z, d2, ez;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], 1'b1, lat, bcnt, q, r, z, d2);
      total++; if (q !== tq[i] || r !== tr[i] || z !== (tb[i] == 16'd0))
        begin bad++; $display("FAIL signed_%0d got=%h r%h z%b want=%h r%h", i, q, r, z, tq[i], tr[i]); end
    end
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom); b = (i == 5) ? 16'd0 : 16'($urandom);
      model(a, b, 1'b1, eq, er, ez);
      do_op(a, b, 1'b1, lat, bcnt, q, r, z, d2);
      total++; if (q !== eq || r !== er || z !== ez || lat != ((b == 0) ? 0 : 16))
        begin bad++; $display("FAIL srand_%0d %h/%h got=%h r%h lat=%0d want=%h r%h", i, a, b, q, r, lat, eq, er); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
